cpu_core_mem: RTL and testbench

//  Parametrised successor of the single-cycle lab CPU. Self-contained core: PC, decoder, register file, ALU, branch/jump unit.

---
 rtl/cpu_core_mem.sv | 157 +++++++++++++++
 tb/tb_cpu_core_mem.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_mem.sv
// Single-issue core: PC, decoder, register file, ALU, branch/jump unit and a stalling data-memory port.
// Loads and stores park the core in MEM until MEM_BUSYWAIT drops; everything else retires in one cycle.
module cpu_core_mem #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int PC_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [PC_W-1:0]   PC,
    input  logic [31:0]       INSTRUCTION,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [DATA_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              HALTED_STALL
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic {
        S_RUN = 1'b0,
        S_MEM = 1'b1
    } state_e;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;
    localparam logic [7:0] OP_LWD   = 8'd8;
    localparam logic [7:0] OP_LWI   = 8'd9;
    localparam logic [7:0] OP_SWD   = 8'd10;
    localparam logic [7:0] OP_SWI   = 8'd11;
    localparam logic [7:0] OP_BNE   = 8'd12;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [AW-1:0]     ld_rd_q, ld_rd_d;

    logic              reg_we;
    logic [AW-1:0]     reg_waddr;
    logic [DATA_W-1:0] reg_wdata;

    logic [7:0]        opcode;
    logic [AW-1:0]     rd_idx, rs1_idx, rs2_idx;
    logic [DATA_W-1:0] rs1_val, rs2_val, imm_ext, diff;
    logic [PC_W-1:0]   pc_plus4, br_target;

    assign opcode    = INSTRUCTION[31:24];
    assign rd_idx    = AW'(INSTRUCTION[23:16]);
    assign rs1_idx   = AW'(INSTRUCTION[15:8]);
    assign rs2_idx   = AW'(INSTRUCTION[7:0]);
    assign rs1_val   = regs_q[rs1_idx];
    assign rs2_val   = regs_q[rs2_idx];
    assign imm_ext   = DATA_W'($signed(INSTRUCTION[7:0]));
    assign diff      = rs1_val - rs2_val;
    assign pc_plus4  = pc_q + PC_W'(4);
    assign br_target = pc_plus4 + (PC_W'($signed(INSTRUCTION[23:16])) << 2);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ld_rd_d     = ld_rd_q;
        reg_we      = 1'b0;
        reg_waddr   = rd_idx;
        reg_wdata   = '0;
        case (state_q)
            S_RUN: begin
                pc_d = pc_plus4;
                case (opcode)
                    OP_LOADI: begin reg_we = 1'b1; reg_wdata = imm_ext;           end
                    OP_MOV:   begin reg_we = 1'b1; reg_wdata = rs2_val;           end
                    OP_ADD:   begin reg_we = 1'b1; reg_wdata = rs1_val + rs2_val; end
                    OP_SUB:   begin reg_we = 1'b1; reg_wdata = diff;              end
                    OP_AND:   begin reg_we = 1'b1; reg_wdata = rs1_val & rs2_val; end
                    OP_OR:    begin reg_we = 1'b1; reg_wdata = rs1_val | rs2_val; end
                    OP_J:     pc_d = br_target;
                    OP_BEQ:   if (diff == '0) pc_d = br_target;
                    OP_BNE:   if (diff != '0) pc_d = br_target;
                    OP_LWD, OP_LWI: begin
                        // The destination is captured now because INSTRUCTION is not trusted during MEM.
                        pc_d       = pc_q;
                        state_d    = S_MEM;
                        mem_read_d = 1'b1;
                        ld_rd_d    = rd_idx;
                        mem_addr_d = (opcode == OP_LWD) ? rs2_val : imm_ext;
                    end
                    OP_SWD, OP_SWI: begin
                        pc_d        = pc_q;
                        state_d     = S_MEM;
                        mem_write_d = 1'b1;
                        mem_wdata_d = rs1_val;
                        mem_addr_d  = (opcode == OP_SWD) ? rs2_val : imm_ext;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (!MEM_BUSYWAIT) begin
                    if (mem_read_q) begin
                        reg_we    = 1'b1;
                        reg_waddr = ld_rd_q;
                        reg_wdata = MEM_RDATA;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    pc_d        = pc_plus4;
                    state_d     = S_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_RUN;
            pc_q        <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_rd_q     <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_rd_q     <= ld_rd_d;
            if (reg_we) regs_q[reg_waddr] <= reg_wdata;
        end
    end

    assign PC           = pc_q;
    assign MEM_READ     = mem_read_q;
    assign MEM_WRITE    = mem_write_q;
    assign MEM_ADDRESS  = mem_addr_q;
    assign MEM_WDATA    = mem_wdata_q;
    assign HALTED_STALL = (state_q == S_MEM);
endmodule

// File: tb/tb_cpu_core_mem.sv
// Bench for cpu_core_mem: an ISA-level model predicts the fetch trace and memory requests,
// a monitor pops and compares them while a behavioural memory answers requests with programmable wait.
module tb_cpu_core_mem;
    localparam int DW     = 8;
    localparam int NR     = 8;
    localparam int PW     = 32;
    localparam int PROG_N = 64;

    // Clock and DUT signals
    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [PW-1:0] PC;
    logic [31:0]   INSTRUCTION;
    logic          MEM_READ, MEM_WRITE, HALTED_STALL;
    logic [DW-1:0] MEM_ADDRESS, MEM_WDATA;
    logic [DW-1:0] MEM_RDATA = '0;
    logic          MEM_BUSYWAIT = 1'b0;

    always #5 CLK = ~CLK;

    cpu_core_mem #(.DATA_W(DW), .NREGS(NR), .PC_W(PW)) dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .HALTED_STALL(HALTED_STALL)
    );

    logic [31:0] prog [PROG_N];
    logic [7:0]  init_mem [256];
    logic [7:0]  resp_mem [256];
    assign INSTRUCTION = prog[PC[7:2]];

    logic [31:0] exp_pc_q[$];
    logic [17:0] exp_mem_q[$];   // {write, read, address, wdata}
    int total = 0;
    int bad = 0;
    int force_wait = -1;
    bit mon_en = 1'b0;
    logic [31:0] last_pc = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    // Reference model: executes the program instruction by instruction.
    task automatic model_run(input int nsteps);
        logic [31:0] pc, ins, nxt, tgt;
        logic [7:0]  r [NR];
        logic [7:0]  dm [256];
        logic [7:0]  a, b, imm;
        int rd, soff;
        pc = 0;
        foreach (r[i]) r[i] = 8'h00;
        foreach (dm[i]) dm[i] = init_mem[i];
        exp_pc_q.delete();
        exp_mem_q.delete();
        for (int s = 0; s < nsteps; s++) begin
            ins = prog[(pc / 4) % PROG_N];
            exp_pc_q.push_back(pc);
            rd   = int'(ins[23:16]) % NR;
            a    = r[int'(ins[15:8]) % NR];
            b    = r[int'(ins[7:0]) % NR];
            imm  = ins[7:0];
            soff = $signed(ins[23:16]);
            nxt  = pc + 4;
            tgt  = pc + 32'(4 + soff * 4);
            case (ins[31:24])
                8'd0:  r[rd] = imm;
                8'd1:  r[rd] = b;
                8'd2:  r[rd] = a + b;
                8'd3:  r[rd] = a - b;
                8'd4:  r[rd] = a & b;
                8'd5:  r[rd] = a | b;
                8'd6:  nxt = tgt;
                8'd7:  if (a == b) nxt = tgt;
                8'd12: if (a != b) nxt = tgt;
                8'd8:  begin r[rd] = dm[b];   exp_mem_q.push_back({2'b01, b, 8'h00});   end
                8'd9:  begin r[rd] = dm[imm]; exp_mem_q.push_back({2'b01, imm, 8'h00}); end
                8'd10: begin dm[b] = a;       exp_mem_q.push_back({2'b10, b, a});       end
                8'd11: begin dm[imm] = a;     exp_mem_q.push_back({2'b10, imm, a});     end
                default: ;
            endcase
            pc = nxt;
        end
    endtask

    // Behavioural data memory with per-request wait states.
    int wait_left = 0;
    bit req_seen = 1'b0;
    always @(negedge CLK) begin
        MEM_RDATA = 8'($urandom);
        if (RESET || !(MEM_READ || MEM_WRITE)) begin
            MEM_BUSYWAIT = 1'b0;
            req_seen = 1'b0;
        end else begin
            if (!req_seen) begin
                req_seen = 1'b1;
                wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
            end else if (wait_left > 0) begin
                wait_left--;
            end
            MEM_BUSYWAIT = (wait_left > 0);
            if (!MEM_BUSYWAIT) begin
                if (MEM_READ) MEM_RDATA = resp_mem[MEM_ADDRESS];
                else resp_mem[MEM_ADDRESS] = MEM_WDATA;
            end
        end
    end

    // Monitor: one fetch per RUN cycle, one request per stall, frozen outputs while stalled.
    int stall_len = 0;
    logic [49:0] held;
    logic [17:0] em;
    always @(negedge CLK) begin
        if (!mon_en) begin
            stall_len = 0;
        end else if (!HALTED_STALL) begin
            if (stall_len > 0 && force_wait >= 0) check("stall_len", stall_len, force_wait + 1);
            stall_len = 0;
            check("idle_req", {MEM_READ, MEM_WRITE}, 2'b00);
            if (exp_pc_q.size() == 0) check("extra_fetch", PC, 64'hx);
            else begin
                check("fetch_pc", PC, exp_pc_q.pop_front());
                last_pc = PC;
            end
        end else begin
            if (stall_len == 0) begin
                if (exp_mem_q.size() == 0) check("extra_req", {MEM_WRITE, MEM_READ, MEM_ADDRESS}, 64'hx);
                else begin
                    em = exp_mem_q.pop_front();
                    check("mem_req", {MEM_WRITE, MEM_READ, MEM_ADDRESS, MEM_WRITE ? MEM_WDATA : 8'h00}, em);
                end
                held = {MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WDATA, PC};
            end else begin
                check("stall_hold", {MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WDATA, PC}, held);
            end
            stall_len++;
        end
    end

    task automatic apply_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic run_phase(input string name, input int nsteps, input int fw);
        bit done;
        force_wait = fw;
        last_pc = '0;
        model_run(nsteps);
        foreach (resp_mem[i]) resp_mem[i] = init_mem[i];
        @(posedge CLK);
        #1;
        apply_reset();
        check({name, "_rst_pc"}, PC, 0);
        check({name, "_rst_req"}, {MEM_READ, MEM_WRITE, HALTED_STALL}, 3'b000);
        mon_en = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge CLK);
            if (exp_pc_q.size() == 0 && exp_mem_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        #1 mon_en = 1'b0;
        check({name, "_timeout"}, done, 1'b1);
    endtask

    task automatic fill_nop();
        foreach (prog[i]) prog[i] = 32'hFF00_0000;
    endtask

    task automatic gen_random_prog();
        int k;
        logic [7:0] op, d;
        for (int i = 0; i < PROG_N; i++) begin
            k  = $urandom_range(0, 13);
            op = (k == 13) ? 8'($urandom_range(13, 255)) : 8'(k);
            d  = 8'($urandom);
            if (op == 8'd6) d = 8'($urandom_range(0, 4));
            else if (op == 8'd7 || op == 8'd12) d = 8'($urandom_range(0, 6)) - 8'd2;
            prog[i] = {op, d, 8'($urandom), 8'($urandom)};
        end
    endtask

    initial begin
        foreach (init_mem[i]) init_mem[i] = 8'($urandom);

        // ALU, wrap, branches, slow store, load-after-store, illegal opcode, backward jump
        fill_nop();
        prog[0]  = mk(8'd0, 8'd1, 8'd0, 8'd5);
        prog[1]  = mk(8'd0, 8'd2, 8'd0, 8'd3);
        prog[2]  = mk(8'd3, 8'd3, 8'd1, 8'd2);
        prog[3]  = mk(8'd11, 8'd0, 8'd3, 8'h20);
        prog[4]  = mk(8'd0, 8'd4, 8'd0, 8'h7F);
        prog[5]  = mk(8'd2, 8'd4, 8'd4, 8'd4);
        prog[6]  = mk(8'd11, 8'd0, 8'd4, 8'h21);
        prog[7]  = mk(8'd7, 8'd1, 8'd1, 8'd1);
        prog[8]  = mk(8'd0, 8'd6, 8'd0, 8'h11);
        prog[9]  = mk(8'd12, 8'd5, 8'd1, 8'd1);
        prog[10] = mk(8'd11, 8'd0, 8'd1, 8'h10);
        prog[11] = mk(8'd9, 8'd5, 8'd0, 8'h10);
        prog[12] = mk(8'd11, 8'd0, 8'd5, 8'h30);
        prog[13] = 32'hFF12_3456;
        prog[14] = mk(8'd11, 8'd0, 8'd6, 8'h31);
        prog[15] = mk(8'd6, 8'h80, 8'd0, 8'd0);
        run_phase("dir", 16, 3);
        check("dir_jump_pc", last_pc, 32'hFFFF_FE40);

        // Load abandoned by reset while memory is busy
        fill_nop();
        prog[0] = mk(8'd9, 8'd5, 8'd0, 8'h10);
        prog[1] = mk(8'd11, 8'd0, 8'd5, 8'h41);
        init_mem[8'h10] = 8'hA5;
        foreach (resp_mem[i]) resp_mem[i] = init_mem[i];
        force_wait = 20;
        @(posedge CLK);
        #1;
        apply_reset();
        @(posedge CLK);
        #1;
        check("abort_req", {MEM_READ, MEM_WRITE, HALTED_STALL}, 3'b101);
        @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("abort_drop", {MEM_READ, MEM_WRITE, HALTED_STALL}, 3'b000);
        check("abort_pc", PC, 0);
        RESET = 1'b0;

        // Zero-wait load, result used by the next instruction
        run_phase("load", 2, 0);

        // beq backwards at PC=8
        fill_nop();
        prog[0] = mk(8'd0, 8'd1, 8'd0, 8'd1);
        prog[2] = mk(8'd7, 8'hFE, 8'd1, 8'd1);
        run_phase("beq", 5, -1);
        check("beq_last_pc", last_pc, 32'd8);

        // Jump -128 words from PC=0 wraps the PC
        fill_nop();
        prog[0] = mk(8'd6, 8'h80, 8'd0, 8'd0);
        run_phase("jmp", 2, -1);
        check("jmp_last_pc", last_pc, 32'hFFFF_FE04);

        for (int r = 0; r < 3; r++) begin
            gen_random_prog();
            foreach (init_mem[i]) init_mem[i] = 8'($urandom);
            run_phase("rnd", 200, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
